// File: rtl/updown_sweep_arbiter_pkg.sv
// Shared definitions for the up/down sweep arbiter: state encoding,
// default widths and a one-hot decode helper.
package updown_sweep_arbiter_pkg;

    localparam int CW_DEF   = 5;
    localparam int LENW_DEF = 8;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_RUN   = 2'b11,
        ST_DONE  = 2'b10
    } state_t;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic int onehot_index(input logic [NREQ_MAX-1:0] oh);
        int idx;
        idx = 0;
        for (int b = 0; b < NREQ_MAX; b++) begin
            if (oh[b]) begin
                idx = b;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/updown_sweep_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from the slot after
// the last winner, wrapping around, and returns the first requester found.
module updown_sweep_arbiter_rr_pick
    import updown_sweep_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_winner,
    output logic            o_valid
);

    // Rotating priority search; the last winner is visited last.
    always_comb begin
        int idx;
        o_winner = '0;
        o_valid  = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(i_last) + k) % NREQ;
            if (!o_valid && i_req[idx]) begin
                o_winner[idx] = 1'b1;
                o_valid       = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/updown_sweep_arbiter.sv
// Round-robin owner of a shared up/down counter. Each winner gets one
// sweep: the counter is cleared, stepped for len clocks, and its final
// count is returned with a one-cycle done pulse.
module updown_sweep_arbiter
    import updown_sweep_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [CW-1:0]        result,
    output logic                 ctr_reset,
    output logic                 ctr_enable,
    input  logic [CW-1:0]        ctr_count,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);

    state_t              r_state;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [CW-1:0]       r_result;
    logic                r_ctr_reset;
    logic                r_ctr_enable;
    logic                r_busy;
    logic [IW-1:0]       r_last_winner;
    logic [IW-1:0]       r_winner;
    logic [LENW-1:0]     r_remaining;

    logic [NREQ-1:0]     w_pick_oh;
    logic                w_pick_valid;
    logic [NREQ_MAX-1:0] w_pick_oh8;
    logic [IW-1:0]       w_pick_idx;
    logic [LENW-1:0]     w_grant_len;
    logic                w_owner_req;

    updown_sweep_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_last   (r_last_winner),
        .o_winner (w_pick_oh),
        .o_valid  (w_pick_valid)
    );

    // Decode the picker's one-hot result into an index and fetch its length.
    always_comb begin
        w_pick_oh8               = '0;
        w_pick_oh8[NREQ-1:0]     = w_pick_oh;
        w_pick_idx               = IW'(onehot_index(w_pick_oh8));
        w_grant_len              = len[int'(w_pick_idx)*LENW +: LENW];
        w_owner_req              = req[r_winner];
    end

    // Sweep FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_done        <= '0;
            r_result      <= '0;
            r_ctr_reset   <= 1'b1;
            r_ctr_enable  <= 1'b0;
            r_busy        <= 1'b0;
            r_last_winner <= IW'(NREQ - 1);
            r_winner      <= '0;
            r_remaining   <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_ctr_enable <= 1'b0;
                    if (w_pick_valid) begin
                        r_gnt       <= w_pick_oh;
                        r_winner    <= w_pick_idx;
                        r_remaining <= w_grant_len;
                        r_ctr_reset <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CLEAR;
                    end else begin
                        r_ctr_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    r_ctr_reset <= 1'b0;
                    if (!w_owner_req) begin
                        // Owner walked away: release without a completion.
                        r_gnt         <= '0;
                        r_ctr_enable  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_last_winner <= r_winner;
                        r_state       <= ST_IDLE;
                    end else if (r_remaining != LENW'(0)) begin
                        r_ctr_enable <= 1'b1;
                        r_state      <= ST_RUN;
                    end else begin
                        r_ctr_enable <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    r_ctr_reset <= 1'b0;
                    if (!w_owner_req) begin
                        r_gnt         <= '0;
                        r_ctr_enable  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_last_winner <= r_winner;
                        r_state       <= ST_IDLE;
                    end else if (r_remaining <= LENW'(1)) begin
                        // Last enabled cycle ends at this edge.
                        r_remaining  <= '0;
                        r_ctr_enable <= 1'b0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_remaining  <= r_remaining - LENW'(1);
                        r_ctr_enable <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Counter has settled on its final value; report it.
                    r_done        <= r_gnt;
                    r_result      <= ctr_count;
                    r_gnt         <= '0;
                    r_ctr_reset   <= 1'b0;
                    r_ctr_enable  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_last_winner <= r_winner;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_gnt        <= '0;
                    r_ctr_reset  <= 1'b1;
                    r_ctr_enable <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign result     = r_result;
    assign ctr_reset  = r_ctr_reset;
    assign ctr_enable = r_ctr_enable;
    assign busy       = r_busy;

endmodule

// File: tb/tb_updown_sweep_arbiter.sv
// Directed bench for updown_sweep_arbiter with a bouncing-counter model and
// a grant/done scoreboard checked by an independent monitor.
module tb_updown_sweep_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 5;
    localparam int LENW = 8;

    typedef struct {
        int idx;
        int res;
    } done_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*LENW-1:0] len = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [CW-1:0]        result;
    logic                 ctr_reset;
    logic                 ctr_enable;
    logic [CW-1:0]        ctr_count;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int exp_gnt_q[$];
    done_t exp_done_q[$];

    logic [CW-1:0] cnt_m = 5'd0;
    logic          up_m  = 1'b1;
    int en_steps  = 0;
    int clr_steps = 0;

    updown_sweep_arbiter #(.NREQ(NREQ), .CW(CW), .LENW(LENW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .len        (len),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .ctr_reset  (ctr_reset),
        .ctr_enable (ctr_enable),
        .ctr_count  (ctr_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Counter that bounces 0..15..0, spending one step turning at each end.
    always @(posedge clk) begin
        if (ctr_reset) begin
            cnt_m <= 5'd0;
            up_m  <= 1'b1;
        end else if (ctr_enable) begin
            if (up_m) begin
                if (cnt_m == 5'd15) up_m <= 1'b0;
                else                cnt_m <= cnt_m + 5'd1;
            end else begin
                if (cnt_m == 5'd0) up_m <= 1'b1;
                else               cnt_m <= cnt_m - 5'd1;
            end
        end
    end
    assign ctr_count = cnt_m;

    // Count clock edges that saw enable / clear asserted.
    always @(posedge clk) begin
        if (ctr_enable) en_steps  <= en_steps + 1;
        if (ctr_reset)  clr_steps <= clr_steps + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops expected grants on each rising grant and expected
    // completions on each done pulse.
    logic [NREQ-1:0] prev_gnt  = '0;
    logic [NREQ-1:0] prev_done = '0;
    int    mon_gidx;
    done_t mon_d;
    always @(negedge clk) begin
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (gnt != '0 && prev_gnt == '0) begin
            if (exp_gnt_q.size() == 0) begin
                chk("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                mon_gidx = exp_gnt_q.pop_front();
                chk("gnt_order", 32'(gnt), 32'd1 << mon_gidx);
            end
        end
        if (done != '0) begin
            chk("done_single", 32'(prev_done), 32'd0);
            if (exp_done_q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                mon_d = exp_done_q.pop_front();
                chk("done_owner", 32'(done), 32'd1 << mon_d.idx);
                chk("result", 32'(result), 32'(mon_d.res));
            end
        end
        prev_gnt  = gnt;
        prev_done = done;
    end

    task automatic set_len(input int i, input int v);
        len[i*LENW +: LENW] = LENW'(v);
    endtask

    task automatic push_done(input int i, input int r);
        done_t d;
        d.idx = i;
        d.res = r;
        exp_done_q.push_back(d);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done == '0 && cyc < 300);
        if (done == '0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout waited=%0d cycles required=done pulse", cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int en0;
        int cl0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ctr_reset", 32'(ctr_reset), 32'd1);
        chk("rst_ctr_enable", 32'(ctr_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ctr_reset", 32'(ctr_reset), 32'd0);

        // Single requester, len 3
        en0 = en_steps; cl0 = clr_steps;
        set_len(0, 3); req = 4'b0001;
        exp_gnt_q.push_back(0); push_done(0, 3);
        @(negedge clk);
        chk("t1_gnt_latency", 32'(gnt), 32'd1);
        chk("t1_clear", 32'(ctr_reset), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(cyc); req = 4'b0000;
        chk("t1_done_latency", 32'(cyc), 32'd5);
        chk("t1_enable_steps", 32'(en_steps - en0), 32'd3);
        chk("t1_clear_steps", 32'(clr_steps - cl0), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Fresh reset, all four requesting with len 1: order 0,1,2,3,0
        reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
        exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
        push_done(0, 1); push_done(1, 1); push_done(2, 1); push_done(3, 1); push_done(0, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(cyc);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // Zero-length sweep on requester 1
        en0 = en_steps;
        set_len(1, 0); req = 4'b0010;
        exp_gnt_q.push_back(1); push_done(1, 0);
        @(negedge clk);
        wait_done(cyc); req = 4'b0000;
        chk("t4_done_latency", 32'(cyc), 32'd2);
        chk("t4_enable_steps", 32'(en_steps - en0), 32'd0);
        repeat (2) @(negedge clk);

        // Long sweep on requester 2: 0..15, turn, down to 11
        en0 = en_steps;
        set_len(2, 20); req = 4'b0100;
        exp_gnt_q.push_back(2); push_done(2, 11);
        @(negedge clk);
        wait_done(cyc); req = 4'b0000;
        chk("t3_done_latency", 32'(cyc), 32'd22);
        chk("t3_enable_steps", 32'(en_steps - en0), 32'd20);
        repeat (2) @(negedge clk);

        // Abandon after 4 RUN cycles
        set_len(0, 10); req = 4'b0001;
        exp_gnt_q.push_back(0);
        @(negedge clk);
        en0 = en_steps;
        repeat (4) @(negedge clk);
        chk("t5_running", 32'(ctr_enable), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("t5_gnt_drop", 32'(gnt), 32'd0);
        chk("t5_enable_drop", 32'(ctr_enable), 32'd0);
        chk("t5_busy_drop", 32'(busy), 32'd0);
        chk("t5_result_held", 32'(result), 32'd11);
        chk("t5_enable_steps", 32'(en_steps - en0), 32'd4);
        repeat (3) @(negedge clk);
        set_len(0, 1); set_len(1, 2);
        exp_gnt_q.push_back(1); exp_gnt_q.push_back(0);
        push_done(1, 2); push_done(0, 1);
        req = 4'b0011;
        wait_done(cyc); req = 4'b0001;
        wait_done(cyc); req = 4'b0000;
        repeat (2) @(negedge clk);

        // Async reset in the middle of a RUN
        set_len(3, 30); req = 4'b1000;
        exp_gnt_q.push_back(3);
        @(negedge clk);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_result", 32'(result), 32'd0);
        chk("t6_rst_ctr_reset", 32'(ctr_reset), 32'd1);
        chk("t6_rst_ctr_enable", 32'(ctr_enable), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        set_len(3, 2); req = 4'b1000;
        exp_gnt_q.push_back(3); push_done(3, 2);
        en0 = en_steps;
        @(negedge clk);
        chk("t6_new_clear", 32'(ctr_reset), 32'd1);
        chk("t6_new_enable", 32'(ctr_enable), 32'd0);
        wait_done(cyc); req = 4'b0000;
        chk("t6_done_latency", 32'(cyc), 32'd4);
        chk("t6_enable_steps", 32'(en_steps - en0), 32'd2);

        repeat (3) @(negedge clk);
        chk("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
